// File: rtl/control_unit_fsm_pkg.sv
// Shared encodings for the control unit: FSM states, ALU opcodes and the
// instruction-class fields it decodes.
package control_unit_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch0, StFetch1, StFetch2, StPcInc, StDecode,
        StExecDp, StExecBr, StMem0, StMem1, StMem2, StFault
    } state_e;

    typedef enum logic [1:0] {ClsDp, ClsMem, ClsBr, ClsUndef} iclass_e;

    localparam logic [3:0] AluAdd = 4'b0100;
    localparam logic [3:0] AluSub = 4'b0010;
    localparam logic [3:0] AluMov = 4'b1101;

    localparam int unsigned IrClassHi = 27;
    localparam int unsigned IrClassLo = 25;
    localparam int unsigned IrImmBit  = 25;
    localparam int unsigned IrOpHi    = 24;
    localparam int unsigned IrOpLo    = 21;
    localparam int unsigned IrUBit    = 23;
    localparam int unsigned IrSBit    = 20;
    localparam int unsigned IrLBit    = 20;

    function automatic iclass_e decode_class(logic [31:0] ir);
        logic [2:0] cls;
        cls = ir[IrClassHi:IrClassLo];
        if (cls[2:1] == 2'b00) return ClsDp;
        if (cls == 3'b010)     return ClsMem;
        if (cls == 3'b101)     return ClsBr;
        return ClsUndef;
    endfunction

    // TST/TEQ/CMP/CMN only set flags and never write a destination register.
    function automatic logic is_test_op(logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/control_unit_fsm_if.sv
// Control-unit bus: instruction/handshake inputs and datapath strobes.
// master = control unit, slave = datapath/memory side.
interface control_unit_fsm_if;
    logic [31:0] ir;
    logic        mfc;
    logic        cond_ok;
    logic        mfa;
    logic        mem_rw;
    logic        mar_load;
    logic        ir_load;
    logic        load;
    logic        loadpc;
    logic        ir_cu;
    logic [3:0]  cu_rslct;
    logic [3:0]  alu_op;
    logic        alu_imm;
    logic        pc4_sel;
    logic        br_sel;
    logic        mdr_sel;
    logic        flags_load;
    logic        undef;
    logic        bus_err;

    modport master (
        input  ir, mfc, cond_ok,
        output mfa, mem_rw, mar_load, ir_load, load, loadpc, ir_cu, cu_rslct,
               alu_op, alu_imm, pc4_sel, br_sel, mdr_sel, flags_load, undef, bus_err
    );

    modport slave (
        output ir, mfc, cond_ok,
        input  mfa, mem_rw, mar_load, ir_load, load, loadpc, ir_cu, cu_rslct,
               alu_op, alu_imm, pc4_sel, br_sel, mdr_sel, flags_load, undef, bus_err
    );
endinterface

// File: rtl/mfc_wait_timer.sv
// Counts cycles spent waiting for MFC; timeout_o flags the last allowed cycle
// so the FSM can fall into FAULT when MFC still has not arrived.
module mfc_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);
    localparam logic [7:0] Limit = 8'(MAX_WAIT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != 8'hff) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // The cycle that would bring the count to MAX_WAIT is the final one.
    assign timeout_o = en_i && (cnt_q >= Limit);
endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle Moore control unit: fetch, PC increment, decode and execute of
// data-processing, LDR/STR immediate and B instructions.
module control_unit_fsm
    import control_unit_fsm_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [3:0]  PC_REG   = 4'd15
) (
    input  logic                clk,
    input  logic                rst,
    control_unit_fsm_if.master  bus
);
    state_e  state_q, state_d;
    iclass_e iclass;
    logic    timeout;
    logic    wait_clr, wait_en;
    logic    unused_ir;

    assign iclass    = decode_class(bus.ir);
    assign wait_clr  = (state_q == StFetch2) || (state_q == StMem2);
    assign wait_en   = (state_q == StFetch1) || (state_q == StMem1);
    assign unused_ir = ^{bus.ir[31:28], bus.ir[19:0]};

    mfc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_mfc_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wait_clr),
        .en_i      (wait_en),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StFetch0;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch0: state_d = StFetch1;
            // MFC sampled on the timeout cycle still counts as success.
            StFetch1: begin
                if (bus.mfc)      state_d = StFetch2;
                else if (timeout) state_d = StFault;
            end
            StFetch2: state_d = StPcInc;
            StPcInc:  state_d = StDecode;
            StDecode: begin
                if (!bus.cond_ok) begin
                    state_d = StFetch0;
                end else begin
                    case (iclass)
                        ClsDp:   state_d = StExecDp;
                        ClsMem:  state_d = StMem0;
                        ClsBr:   state_d = StExecBr;
                        default: state_d = StFetch0;
                    endcase
                end
            end
            StExecDp, StExecBr: state_d = StFetch0;
            StMem0: state_d = StMem1;
            StMem1: begin
                if (bus.mfc)      state_d = StMem2;
                else if (timeout) state_d = StFault;
            end
            StMem2:  state_d = StFetch0;
            StFault: state_d = StFault;
            default: state_d = StFetch0;
        endcase
    end

    // Outputs are forced to their idle values while reset is held.
    always_comb begin
        bus.mfa        = 1'b0;
        bus.mem_rw     = 1'b0;
        bus.mar_load   = 1'b0;
        bus.ir_load    = 1'b0;
        bus.load       = 1'b0;
        bus.loadpc     = 1'b0;
        bus.ir_cu      = 1'b0;
        bus.cu_rslct   = PC_REG;
        bus.alu_op     = 4'b0000;
        bus.alu_imm    = 1'b0;
        bus.pc4_sel    = 1'b0;
        bus.br_sel     = 1'b0;
        bus.mdr_sel    = 1'b0;
        bus.flags_load = 1'b0;
        bus.undef      = 1'b0;
        bus.bus_err    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch0: begin
                    bus.mar_load = 1'b1;
                    bus.alu_op   = AluMov;
                end
                StFetch1: begin
                    bus.mfa    = 1'b1;
                    bus.mem_rw = 1'b1;
                end
                StFetch2: begin
                    bus.mfa     = 1'b1;
                    bus.mem_rw  = 1'b1;
                    bus.ir_load = 1'b1;
                end
                StPcInc: begin
                    bus.alu_op  = AluAdd;
                    bus.pc4_sel = 1'b1;
                    bus.loadpc  = 1'b1;
                end
                StDecode: bus.undef = bus.cond_ok && (iclass == ClsUndef);
                StExecDp: begin
                    bus.ir_cu      = 1'b1;
                    bus.alu_op     = bus.ir[IrOpHi:IrOpLo];
                    bus.alu_imm    = bus.ir[IrImmBit];
                    bus.flags_load = bus.ir[IrSBit];
                    bus.load       = !is_test_op(bus.ir[IrOpHi:IrOpLo]);
                end
                StExecBr: begin
                    bus.alu_op = AluAdd;
                    bus.br_sel = 1'b1;
                    bus.loadpc = 1'b1;
                end
                StMem0: begin
                    bus.ir_cu    = 1'b1;
                    bus.alu_imm  = 1'b1;
                    bus.mar_load = 1'b1;
                    bus.alu_op   = bus.ir[IrUBit] ? AluAdd : AluSub;
                end
                StMem1: begin
                    bus.mfa    = 1'b1;
                    bus.mem_rw = bus.ir[IrLBit];
                end
                StMem2: begin
                    bus.mfa     = 1'b1;
                    bus.mem_rw  = bus.ir[IrLBit];
                    bus.ir_cu   = bus.ir[IrLBit];
                    bus.load    = bus.ir[IrLBit];
                    bus.mdr_sel = bus.ir[IrLBit];
                end
                StFault: bus.bus_err = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/control_unit_fsm.md
Name: control_unit_fsm

Overview:
- Multi-cycle control unit sitting directly upstream of the register file.
- It sequences fetch, PC increment, decode and execute for a 32-bit ARM-style datapath.
- It drives the register file's LOAD, LOADPC, IR_CU and the control-unit register select, plus the memory handshake (MFA/MFC) and the ALU controls.
- It supports data-processing, LDR/STR with immediate offset, and B; other classes are flagged as undefined.

Parameters:
- MAX_WAIT, 15, cycles allowed for MFC before a bus fault; maximum 255.
- PC_REG, 4'd15, register number used as PC when IR_CU=0.

Ports:
- Clk  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IR  in  32  current instruction-register contents.
- MFC  in  1  memory function complete.
- COND_OK  in  1  condition-field evaluation result for IR[31:28].
- MFA  out  1  memory function active (request).
- MEM_RW  out  1  1 = read, 0 = write.
- MAR_LOAD  out  1  latch ALU output into MAR.
- IR_LOAD  out  1  latch memory data into IR.
- LOAD  out  1  register-file write enable.
- LOADPC  out  1  PC write enable.
- IR_CU  out  1  1 = register selects from IR fields; 0 = from CU_RSLCT.
- CU_RSLCT  out  4  CU-driven register number.
- ALU_OP  out  4  ALU opcode, ARM encoding.
- ALU_IMM  out  1  ALU B operand = immediate/offset.
- PC4_SEL  out  1  ALU B operand = constant 4.
- BR_SEL  out  1  ALU B operand = sign-extended branch offset << 2.
- MDR_SEL  out  1  register-file input = memory data.
- FLAGS_LOAD  out  1  update NZCV.
- UNDEF  out  1  one-cycle pulse on undefined instruction.
- BUS_ERR  out  1  sticky MFC timeout flag.

Behaviour:
- Moore FSM. States: FETCH0, FETCH1, FETCH2, PCINC, DECODE, EXEC_DP, EXEC_BR, MEM0, MEM1, MEM2, FAULT.
- Reset: async to FETCH0. Wait counter = 0. All outputs 0 except IR_CU=0 and CU_RSLCT=PC_REG. RESET mid-operation aborts immediately with no further strobes.
- Default outputs in every state: the reset values above. Each state asserts only what is listed.
- FETCH0: MAR_LOAD=1, ALU_OP=4'b1101 (MOV). Next state FETCH1.
- FETCH1: MFA=1, MEM_RW=1.
  - Stays until MFC=1 is sampled, then goes to FETCH2.
  - Wait counter increments each cycle in this state. If it reaches MAX_WAIT with MFC=0, go to FAULT.
- FETCH2: MFA=1, MEM_RW=1, IR_LOAD=1. Next state PCINC. Wait counter cleared.
- PCINC: ALU_OP=4'b0100 (ADD), PC4_SEL=1, LOADPC=1. Next state DECODE.
- DECODE: no strobes.
  - COND_OK=0 → FETCH0.
  - IR[27:26]=00 → EXEC_DP.
  - IR[27:25]=010 → MEM0.
  - IR[27:25]=101 → EXEC_BR.
  - Otherwise UNDEF=1 for this cycle, next FETCH0.
- EXEC_DP: IR_CU=1, ALU_OP=IR[24:21], ALU_IMM=IR[25], FLAGS_LOAD=IR[20].
  - LOAD=1 unless IR[24:21] is in 1000..1011 (TST/TEQ/CMP/CMN).
  - Next state FETCH0.
- EXEC_BR: ALU_OP=ADD, BR_SEL=1, LOADPC=1. Next state FETCH0.
- MEM0: IR_CU=1, ALU_IMM=1, MAR_LOAD=1. ALU_OP=ADD if IR[23]=1, else SUB (4'b0010). Next state MEM1.
- MEM1: MFA=1, MEM_RW=IR[20]. Same MFC wait and timeout rules as FETCH1. Next state MEM2.
- MEM2: MFA=1, MEM_RW=IR[20].
  - If IR[20]=1: IR_CU=1, LOAD=1, MDR_SEL=1.
  - Next state FETCH0. Wait counter cleared.
- FAULT: BUS_ERR=1 and all strobes 0. Exits only on RESET.
- MFC=1 when MFA=0 is ignored.
- MFC=1 on the same cycle the counter reaches MAX_WAIT counts as success; MFC wins.

Decomposition:
- Shared package: state encoding (4-bit), ALU opcode constants (ADD, SUB, MOV), instruction-class field positions.
- One sub-module: mfc_wait_timer. It holds the 8-bit counter with clear/enable inputs and a timeout output.

Test Plan:
- Reset pulse mid-MEM1 → next edge state FETCH0; all strobes 0; IR_CU=0; CU_RSLCT=15.
- ADD R1,R2,R3 (IR=32'hE0821003), MFC after 2 cycles → IR_LOAD 1 cycle, LOADPC in PCINC, EXEC_DP with LOAD=1, ALU_OP=0100, FLAGS_LOAD=0.
- CMP R1,#5 (IR=32'hE3510005) → EXEC_DP: LOAD=0, FLAGS_LOAD=1, ALU_IMM=1.
- LDR R0,[R1,#4] (IR=32'hE5910004) → MEM0 ALU_OP=ADD, MAR_LOAD=1; MEM2 LOAD=1, MDR_SEL=1. Repeat with STR (IR[20]=0) → MEM_RW=0 and no LOAD.
- B with COND_OK=0 → DECODE goes straight to FETCH0 with no LOADPC after PCINC. With COND_OK=1 → EXEC_BR with LOADPC=1, BR_SEL=1.
- MFC held 0 in FETCH1 → BUS_ERR=1 after 15 cycles and stays high until RESET. IR=32'hE7F000F0 → UNDEF pulses 1 cycle.
